branch_comp_pipe: RTL and testbench

BRANCH_COMP_PIPE -- requirements
Module: branch_comp_pipe

---
 rtl/branch_pkg.sv | 71 +++++++
 rtl/branch_cmp_core.sv | 30 +++
 rtl/branch_comp_pipe.sv | 171 +++++++++++++++++
 tb/tb_branch_comp_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Brief    : Shared constants, types and the branch resolve helper for the
//            branch compare pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // funct3 encodings of the conditional branch instructions
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Legal range of the pipeline depth parameter
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 2;

    // Raw comparator flags produced by the compare core
    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } cmp_flags_t;

    // Fully resolved branch result carried by the output stage
    typedef struct packed {
        logic taken;
        logic br_eq;
        logic br_lt;
        logic br_ltu;
        logic mispredict;
        logic illegal;
    } br_result_t;

    // Turn comparator flags plus funct3 and the prediction into a result.
    // Illegal encodings never report taken or mispredict.
    function automatic br_result_t branch_resolve(
        input logic [2:0] funct3,
        input cmp_flags_t flags,
        input logic       pred_taken
    );
        br_result_t res;
        logic       cond;
        logic       legal;
        res   = '0;
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  cond = flags.eq;
            F3_BNE:  cond = ~flags.eq;
            F3_BLT:  cond = flags.lt;
            F3_BGE:  cond = ~flags.lt;
            F3_BLTU: cond = flags.ltu;
            F3_BGEU: cond = ~flags.ltu;
            default: legal = 1'b0;
        endcase
        res.br_eq      = flags.eq;
        res.br_lt      = flags.lt;
        res.br_ltu     = flags.ltu;
        res.illegal    = ~legal;
        res.taken      = legal & cond;
        res.mispredict = legal & (cond != pred_taken);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cmp_core.sv
`default_nettype none
// ============================================================================
// Module   : branch_cmp_core
// Brief    : Combinational XLEN-bit equal / signed-less / unsigned-less
//            comparator built around a single (XLEN+1)-bit subtraction.
// Revision : 1.0 - initial release
// ============================================================================
module branch_cmp_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    // Zero-extended subtraction: the top bit is the unsigned borrow
    logic [XLEN:0] w_diff;

    assign w_diff = {1'b0, src1} - {1'b0, src2};

    // A zero difference in the low XLEN bits means the operands are equal
    assign eq  = (w_diff[XLEN-1:0] == '0);
    assign ltu = w_diff[XLEN];
    // Equal signs: magnitude order decides; differing signs: negative one is less
    assign lt  = (src1[XLEN-1] == src2[XLEN-1]) ? ltu : src1[XLEN-1];

endmodule
`default_nettype wire

// File: rtl/branch_comp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : branch_comp_pipe
// Brief    : Pipelined branch condition evaluator with valid/ready handshakes,
//            flush, and saturating taken / mispredict statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_comp_pipe
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             br_eq,
    output logic             br_lt,
    output logic             br_ltu,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    // Depths outside the legal range fall back to the nearest legal structure
    localparam bit               c_two_stage = (STAGES >= STAGES_MAX);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    // Comparator flags for the request currently on the input
    logic       w_eq;
    logic       w_lt;
    logic       w_ltu;
    cmp_flags_t w_flags;

    // Output stage state
    logic       r_out_valid;
    br_result_t r_out_res;

    // Handshake helpers
    logic       w_out_valid;
    logic       w_drain;
    logic       w_accept;
    logic       w_deliver;
    logic       w_slot_free;

    // Statistics
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    branch_cmp_core #(
        .XLEN (XLEN)
    ) u_cmp (
        .src1 (src1),
        .src2 (src2),
        .eq   (w_eq),
        .lt   (w_lt),
        .ltu  (w_ltu)
    );

    assign w_flags = '{eq: w_eq, lt: w_lt, ltu: w_ltu};

    // Reset masks the output immediately, before the registers clear
    assign w_out_valid = r_out_valid & ~rst;
    // Last stage vacates this cycle (flush/reset are handled by the registers)
    assign w_drain     = r_out_valid & out_ready;
    assign in_ready    = ~rst & ~flush & w_slot_free;
    assign w_accept    = in_valid & in_ready;
    // A result offered during a flush is discarded, not delivered
    assign w_deliver   = w_out_valid & out_ready & ~flush;

    if (c_two_stage) begin : g_two_stage
        logic       r_s1_valid;
        cmp_flags_t r_s1_flags;
        logic [2:0] r_s1_funct3;
        logic       r_s1_pred;
        logic       w_s1_adv;

        assign w_s1_adv    = r_s1_valid & (~r_out_valid | w_drain);
        assign w_slot_free = ~r_s1_valid | w_s1_adv;

        // Stage 1: capture comparator flags plus the fields needed for decode
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_valid  <= 1'b0;
                r_s1_flags  <= '0;
                r_s1_funct3 <= '0;
                r_s1_pred   <= 1'b0;
            end else if (flush) begin
                r_s1_valid  <= 1'b0;
            end else if (w_accept) begin
                r_s1_valid  <= 1'b1;
                r_s1_flags  <= w_flags;
                r_s1_funct3 <= funct3;
                r_s1_pred   <= pred_taken;
            end else if (w_s1_adv) begin
                r_s1_valid  <= 1'b0;
            end
        end

        // Stage 2: decode funct3, resolve the prediction, hold while stalled
        always_ff @(posedge clk) begin
            if (rst) begin
                r_out_valid <= 1'b0;
                r_out_res   <= '0;
            end else if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_out_res   <= branch_resolve(r_s1_funct3, r_s1_flags, r_s1_pred);
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end else begin : g_one_stage
        assign w_slot_free = ~r_out_valid | w_drain;

        // Single stage: compare, decode and resolve straight into the output
        always_ff @(posedge clk) begin
            if (rst) begin
                r_out_valid <= 1'b0;
                r_out_res   <= '0;
            end else if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_res   <= branch_resolve(funct3, w_flags, pred_taken);
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Count delivered results, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_taken_cnt   <= '0;
            r_mispred_cnt <= '0;
        end else if (w_deliver) begin
            if (r_out_res.taken && (r_taken_cnt != c_cnt_max)) begin
                r_taken_cnt <= r_taken_cnt + c_cnt_one;
            end
            if (r_out_res.mispredict && (r_mispred_cnt != c_cnt_max)) begin
                r_mispred_cnt <= r_mispred_cnt + c_cnt_one;
            end
        end
    end

    assign out_valid   = w_out_valid;
    assign taken       = w_out_valid & r_out_res.taken;
    assign br_eq       = w_out_valid & r_out_res.br_eq;
    assign br_lt       = w_out_valid & r_out_res.br_lt;
    assign br_ltu      = w_out_valid & r_out_res.br_ltu;
    assign mispredict  = w_out_valid & r_out_res.mispredict;
    assign illegal     = w_out_valid & r_out_res.illegal;
    assign taken_cnt   = r_taken_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_comp_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_branch_comp_pipe
// Brief    : Self-checking bench for branch_comp_pipe. Three instances share
//            one stimulus stream: (STAGES=2,CNT_W=16), (STAGES=1,CNT_W=16),
//            (STAGES=2,CNT_W=2). A transaction-level model tracks each one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_comp_pipe;
    import branch_pkg::*;

    localparam int XLEN = 32;
    localparam int NI   = 3;
    localparam int STG  [NI] = '{2, 1, 2};
    localparam int CMAX [NI] = '{65535, 65535, 3};

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            flush;
    logic            out_ready;
    logic            pred_taken;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;

    // Per-instance observed outputs; dres = {taken,eq,lt,ltu,mispredict,illegal}
    logic        rdy  [NI];
    logic        ov   [NI];
    logic [5:0]  dres [NI];
    logic [15:0] tcnt [NI];
    logic [15:0] mcnt [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int ST = (g == 1) ? 1 : 2;
        localparam int CW = (g == 2) ? 2 : 16;
        logic          w_rdy, w_ov, w_tk, w_eq, w_lt, w_ltu, w_mis, w_ill;
        logic [CW-1:0] w_tc, w_mc;

        branch_comp_pipe #(.XLEN(XLEN), .STAGES(ST), .CNT_W(CW)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_ready    (w_rdy),
            .funct3      (funct3),
            .src1        (src1),
            .src2        (src2),
            .pred_taken  (pred_taken),
            .flush       (flush),
            .out_valid   (w_ov),
            .out_ready   (out_ready),
            .taken       (w_tk),
            .br_eq       (w_eq),
            .br_lt       (w_lt),
            .br_ltu      (w_ltu),
            .mispredict  (w_mis),
            .illegal     (w_ill),
            .taken_cnt   (w_tc),
            .mispred_cnt (w_mc)
        );

        assign rdy[g]  = w_rdy;
        assign ov[g]   = w_ov;
        assign dres[g] = {w_tk, w_eq, w_lt, w_ltu, w_mis, w_ill};
        assign tcnt[g] = 16'(w_tc);
        assign mcnt[g] = 16'(w_mc);
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the branch rules
    function automatic logic [5:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input logic p);
        logic eq, lt, ltu, c, il;
        eq  = (a == b);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        il  = 1'b0;
        c   = 1'b0;
        case (f3)
            3'b000:  c = eq;
            3'b001:  c = !eq;
            3'b100:  c = lt;
            3'b101:  c = !lt;
            3'b110:  c = ltu;
            3'b111:  c = !ltu;
            default: il = 1'b1;
        endcase
        return {c & !il, eq, lt, ltu, !il & (c != p), il};
    endfunction

    // In-flight requests per instance: result and acceptance cycle
    logic [5:0] q_r [NI][4];
    int         q_t [NI][4];
    int         q_h [NI];
    int         q_n [NI];
    int         m_tc[NI];
    int         m_mc[NI];
    int         cyc = 0;
    logic       e_ov, e_rdy;
    logic [5:0] popped;

    // Every cycle: compare each instance against the model, then advance it
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            e_ov  = !rst && (q_n[i] > 0) && ((cyc - q_t[i][q_h[i]]) >= STG[i]);
            e_rdy = !rst && !flush && ((q_n[i] < STG[i]) || (e_ov && out_ready));
            chk("out_valid",   i, ov[i],   e_ov);
            chk("in_ready",    i, rdy[i],  e_rdy);
            chk("payload",     i, dres[i], e_ov ? q_r[i][q_h[i]] : 6'd0);
            chk("taken_cnt",   i, tcnt[i], m_tc[i]);
            chk("mispred_cnt", i, mcnt[i], m_mc[i]);
            if (rst) begin
                q_n[i]  = 0;
                q_h[i]  = 0;
                m_tc[i] = 0;
                m_mc[i] = 0;
            end else if (flush) begin
                q_n[i] = 0;
            end else begin
                if (e_ov && out_ready) begin
                    popped = q_r[i][q_h[i]];
                    if (popped[5] && m_tc[i] < CMAX[i]) m_tc[i]++;
                    if (popped[1] && m_mc[i] < CMAX[i]) m_mc[i]++;
                    q_h[i] = (q_h[i] + 1) % 4;
                    q_n[i]--;
                end
                if (in_valid && e_rdy) begin
                    q_r[i][(q_h[i] + q_n[i]) % 4] = model(funct3, src1, src2, pred_taken);
                    q_t[i][(q_h[i] + q_n[i]) % 4] = cyc;
                    q_n[i]++;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic p);
        in_valid = 1'b1; funct3 = f; src1 = a; src2 = b; pred_taken = p;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            1:       return 32'($urandom_range(0, 7));
            2:       return 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    logic [2:0]  df3 [6] = '{F3_BLT, F3_BGEU, F3_BEQ, 3'b010, F3_BEQ, F3_BEQ};
    logic [31:0] da  [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234, 32'd5, 32'd9, 32'd0};
    logic [31:0] db  [6] = '{32'h1, 32'h7FFF_FFFF, 32'h1234, 32'd5, 32'd9, 32'd0};
    logic        dp  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0]  dexp[4] = '{6'h2A, 6'h28, 6'h30, 6'h11};
    int          sent;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = 3'b000; src1 = '0; src2 = '0; pred_taken = 1'b0;
        tick();
        @(negedge clk);
        chk("reset out_valid", 0, ov[0], 1'b0);
        chk("reset in_ready",  0, rdy[0], 1'b0);
        chk("reset taken_cnt", 0, tcnt[0], 16'd0);

        // BLT -1 < 1 with pred not-taken: latency 2 (and 1 for STAGES=1)
        do_reset();
        set_req(F3_BLT, 32'hFFFF_FFFF, 32'h1, 1'b0);
        @(negedge clk);
        chk("blt accepted", 0, rdy[0], 1'b1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("one-stage latency", 1, ov[1], 1'b1);
        chk("one-stage blt",     1, dres[1], 6'h2A);
        chk("two-stage early",   0, ov[0], 1'b0);
        tick();
        @(negedge clk);
        chk("two-stage latency", 0, ov[0], 1'b1);
        chk("two-stage blt",     0, dres[0], 6'h2A);
        tick();
        @(negedge clk);
        chk("blt mispred_cnt", 0, mcnt[0], 16'd1);
        chk("blt taken_cnt",   0, tcnt[0], 16'd1);

        // Directed back-to-back stream incl. illegal funct3 and saturation
        do_reset();
        for (int cy = 0; cy < 9; cy++) begin
            if (cy < 6) set_req(df3[cy], da[cy], db[cy], dp[cy]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (cy >= 2 && cy <= 5) chk("directed result", 0, dres[0], dexp[cy-2]);
            tick();
        end
        @(negedge clk);
        chk("taken_cnt 5",         0, tcnt[0], 16'd5);
        chk("taken_cnt saturated", 2, tcnt[2], 16'd3);
        chk("mispred_cnt 1",       0, mcnt[0], 16'd1);

        // Eight requests with the consumer stalled for cycles 3-5
        do_reset();
        sent = 0;
        for (int cy = 0; cy < 14; cy++) begin
            out_ready = !(cy >= 3 && cy <= 5);
            in_valid  = (sent < 8);
            funct3 = F3_BLTU; src1 = 32'(sent); src2 = 32'd4; pred_taken = 1'b1;
            @(negedge clk);
            if (cy == 3 || cy == 5) chk("stalled in_ready", 0, rdy[0], 1'b0);
            if (cy == 6) chk("resumed in_ready", 0, rdy[0], 1'b1);
            if (cy >= 6 && cy <= 12) chk("throughput", 0, ov[0], 1'b1);
            if (cy == 13) chk("drained", 0, ov[0], 1'b0);
            if (in_valid && rdy[0]) sent++;
            tick();
        end
        chk("accepted count", 0, sent, 8);

        // Flush with two entries in flight and a request on the input
        do_reset();
        out_ready = 1'b0;
        set_req(F3_BEQ, 32'd7, 32'd7, 1'b1);
        tick(); tick();
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("flush in_ready",  0, rdy[0], 1'b0);
        chk("flush presented", 0, ov[0], 1'b1);
        tick(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post-flush out_valid", 0, ov[0], 1'b0);
        chk("post-flush taken_cnt", 0, tcnt[0], 16'd0);
        tick();
        @(negedge clk);
        chk("flushed request absent", 0, ov[0], 1'b0);

        // Reset while the pipeline is full
        do_reset();
        set_req(F3_BEQ, 32'd3, 32'd3, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("pre-reset taken_cnt", 0, tcnt[0], 16'd2);
        chk("reset masks output",  0, ov[0], 1'b0);
        tick(); rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post-reset out_valid",   0, ov[0], 1'b0);
        chk("post-reset taken_cnt",   0, tcnt[0], 16'd0);
        chk("post-reset mispred_cnt", 0, mcnt[0], 16'd0);
        tick();

        // Randomized traffic with occasional flush and reset
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 7);
            funct3     = 3'($urandom_range(0, 7));
            src1       = rnd_val();
            src2       = ($urandom_range(0, 4) == 0) ? src1 : rnd_val();
            pred_taken = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
